// File: rtl/cholesky_array_div_if.sv
// Array-divide channel between the cholesky datapath (master) and the
// six-lane fixed-point divider (slave).
interface cholesky_array_div_if;
  logic             start;
  logic [5:0][26:0] dividends;
  logic [26:0]      divisor;
  logic [5:0][26:0] quotients;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (
    output start, dividends, divisor,
    input  quotients, busy, done, dz
  );

  modport slave (
    input  start, dividends, divisor,
    output quotients, busy, done, dz
  );
endinterface

// File: rtl/cholesky_array_div.sv
// Six-lane Q13.13 signed divider: q = (dividend << 13) / divisor, truncated
// toward zero, sign-magnitude restoring divide at one quotient bit per cycle.
module cholesky_array_div (
  input  logic                        clk,
  input  logic                        rst,
  cholesky_array_div_if.slave         div_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [26:0] QMAX = 27'h3FF_FFFF;

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [26:0]      dvs_mag_q, dvs_mag_d;
  logic             dvs_zero_q, dvs_zero_d;
  logic [5:0]       res_neg_q, res_neg_d;
  logic [5:0]       dvd_nz_q, dvd_nz_d;
  logic [5:0][26:0] rem_q, rem_d;
  logic [5:0][39:0] acc_q, acc_d;
  logic [5:0][26:0] quot_q, quot_d;
  logic             dz_q, dz_d;

  logic [5:0][26:0] in_mag;
  logic [26:0]      in_dvs_mag;
  logic [5:0][27:0] rem_sh;
  logic [5:0][26:0] step_rem;
  logic [5:0][39:0] step_acc;
  logic [5:0][26:0] fin_mag;
  logic [5:0][26:0] fin_q;

  // Per-lane datapath: operand magnitudes, one restoring step, and the
  // saturated/signed result that the step would produce if it were the last.
  always_comb begin
    in_mag   = '0;
    rem_sh   = '0;
    step_rem = '0;
    step_acc = '0;
    fin_mag  = '0;
    fin_q    = '0;
    in_dvs_mag = div_if.divisor[26] ? (~div_if.divisor + 27'd1) : div_if.divisor;
    for (int unsigned i = 0; i < 6; i++) begin
      in_mag[i] = div_if.dividends[i][26] ? (~div_if.dividends[i] + 27'd1)
                                          : div_if.dividends[i];
      // Remainder stays below the divisor, so 27 bits suffice after subtract.
      rem_sh[i] = {rem_q[i], acc_q[i][39]};
      if (rem_sh[i] >= {1'b0, dvs_mag_q}) begin
        step_rem[i] = rem_sh[i][26:0] - dvs_mag_q;
        step_acc[i] = {acc_q[i][38:0], 1'b1};
      end else begin
        step_rem[i] = rem_sh[i][26:0];
        step_acc[i] = {acc_q[i][38:0], 1'b0};
      end
      if (dvs_zero_q) begin
        fin_mag[i] = dvd_nz_q[i] ? QMAX : '0;
      end else if (|step_acc[i][39:26]) begin
        fin_mag[i] = QMAX;
      end else begin
        fin_mag[i] = {1'b0, step_acc[i][25:0]};
      end
      fin_q[i] = (res_neg_q[i] && (fin_mag[i] != '0)) ? (~fin_mag[i] + 27'd1)
                                                       : fin_mag[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvs_mag_d  = dvs_mag_q;
    dvs_zero_d = dvs_zero_q;
    res_neg_d  = res_neg_q;
    dvd_nz_d   = dvd_nz_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    quot_d     = quot_q;
    dz_d       = dz_q;
    case (state_q)
      IDLE, DONE: begin
        if (div_if.start) begin
          dvs_mag_d  = in_dvs_mag;
          dvs_zero_d = (div_if.divisor == '0);
          for (int unsigned i = 0; i < 6; i++) begin
            res_neg_d[i] = div_if.dividends[i][26] ^ div_if.divisor[26];
            dvd_nz_d[i]  = (div_if.dividends[i] != '0);
            rem_d[i]     = '0;
            acc_d[i]     = {in_mag[i], 13'd0};
          end
          cnt_d   = 6'd39;
          state_d = CALC;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = step_rem;
        acc_d = step_acc;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          quot_d  = fin_q;
          dz_d    = dvs_zero_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvs_mag_q  <= '0;
      dvs_zero_q <= 1'b0;
      res_neg_q  <= '0;
      dvd_nz_q   <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      quot_q     <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvs_mag_q  <= dvs_mag_d;
      dvs_zero_q <= dvs_zero_d;
      res_neg_q  <= res_neg_d;
      dvd_nz_q   <= dvd_nz_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      quot_q     <= quot_d;
      dz_q       <= dz_d;
    end
  end

  assign div_if.quotients = quot_q;
  assign div_if.dz        = dz_q;
  assign div_if.busy      = (state_q == CALC);
  assign div_if.done      = (state_q == DONE);

endmodule

// File: tb/tb_cholesky_array_div.sv
// Randomized and directed bench for cholesky_array_div against an
// integer-arithmetic reference of the Q13.13 divide rules.
module tb_cholesky_array_div;

  localparam longint QMAX = 64'sd67108863;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cholesky_array_div_if dif ();

  cholesky_array_div dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned done_cnt = 0;

  longint      op_dvd [6];
  longint      op_dvs;
  logic [26:0] exp_q  [6];
  logic        exp_dz;

  always @(negedge clk) if (dif.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [26:0] ref_q(input longint dvd, input longint dvs);
    longint q;
    if (dvs == 0) begin
      q = (dvd == 0) ? 0 : ((dvd < 0) ? -QMAX : QMAX);
    end else begin
      q = (dvd * 8192) / dvs;
      if (q > QMAX)  q = QMAX;
      if (q < -QMAX) q = -QMAX;
    end
    return q[26:0];
  endfunction

  function automatic longint rnd_val();
    logic [26:0] r;
    r = 27'($urandom);
    case ($urandom_range(0, 3))
      0: return longint'($signed(r));
      1: return longint'($urandom_range(0, 40000)) - 20000;
      2: case ($urandom_range(0, 4))
           0: return 0;
           1: return 1;
           2: return -1;
           3: return -67108864;
           default: return 67108863;
         endcase
      default: return longint'($signed({{10{r[26]}}, r[16:0]}));
    endcase
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < 6; i++) dif.dividends[i] = 27'(op_dvd[i]);
    dif.divisor = 27'(op_dvs);
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < 6; i++) dif.dividends[i] = 27'($urandom);
    dif.divisor = 27'($urandom);
  endtask

  task automatic calc_expected();
    for (int i = 0; i < 6; i++) exp_q[i] = ref_q(op_dvd[i], op_dvs);
    exp_dz = (op_dvs == 0);
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_q%0d", tag, i), 64'(dif.quotients[i]), 64'(exp_q[i]));
    check({tag, "_dz"}, 64'(dif.dz), 64'(exp_dz));
  endtask

  // Waits (bounded) for done; returns cycles since the start edge and busy count.
  task automatic wait_done(output int cycles, output int busy_n);
    cycles = 0;
    busy_n = 0;
    while (dif.done !== 1'b1 && cycles < 100) begin
      if (dif.busy === 1'b1) busy_n++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  // Drives the current operands with start now; caller is between edges.
  task automatic do_op(input string tag, input bit scramble);
    int cyc, bsy;
    calc_expected();
    drive_ops();
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    if (scramble) scramble_inputs();
    wait_done(cyc, bsy);
    check({tag, "_latency"}, 64'(cyc), 64'd40);
    check({tag, "_busycyc"}, 64'(bsy), 64'd40);
    check_results(tag);
  endtask

  initial begin
    int cyc, bsy;
    int unsigned d0;
    rst = 1'b0;
    dif.start = 1'b0;
    dif.dividends = '0;
    dif.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(dif.busy), 64'd0);
    check("rst_done", 64'(dif.done), 64'd0);
    check("rst_dz", 64'(dif.dz), 64'd0);
    check("rst_quot", 64'(dif.quotients), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic single lane
    op_dvd = '{24576, 0, 0, 0, 0, 0};
    op_dvs = 16384;
    do_op("basic", 1'b0);
    @(posedge clk); #1;
    check("done_pulse_width", 64'(dif.done), 64'd0);
    check("hold_q0", 64'(dif.quotients[0]), 64'(exp_q[0]));

    // Signs and truncation
    op_dvd = '{8192, -8192, -24576, 0, 24576, -16384};
    op_dvs = 24576;
    do_op("signs", 1'b1);

    // Divide by zero, then overflow issued back-to-back from DONE
    op_dvd = '{8192, -8192, 0, 1, -67108864, 67108863};
    op_dvs = 0;
    do_op("divzero", 1'b1);
    op_dvd = '{33554432, -33554432, 67108863, -67108864, 1, -1};
    op_dvs = 1;
    do_op("ovf_b2b", 1'b0);
    op_dvd = '{67108863, -67108864, 8192, -8192, 5, 0};
    op_dvs = -67108864;
    do_op("bigdvs_b2b", 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_results("hold");

    // Start during CALC is ignored
    op_dvd = '{1000, -2000, 3000, -4000, 5000, -6000};
    op_dvs = 7;
    calc_expected();
    drive_ops();
    d0 = done_cnt;
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    scramble_inputs();
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    wait_done(cyc, bsy);
    check("ign_latency", 64'(cyc + 10), 64'd40);
    check_results("ign");
    repeat (50) @(posedge clk);
    #1;
    check("ign_one_done", 64'(done_cnt - d0), 64'd1);

    // Reset mid-CALC aborts
    op_dvd = '{-300000, 300000, 1, 2, 3, 4};
    op_dvs = 3;
    drive_ops();
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dif.start = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    check("abort_busy", 64'(dif.busy), 64'd0);
    check("abort_done", 64'(dif.done), 64'd0);
    check("abort_quot", 64'(dif.quotients), 64'd0);
    check("abort_dz", 64'(dif.dz), 64'd0);
    rst = 1'b1;
    dif.start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    do_op("post_abort", 1'b1);

    // Randomized operations, some back-to-back
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 6; i++) op_dvd[i] = rnd_val();
      op_dvs = ($urandom_range(0, 7) == 0) ? 0 : rnd_val();
      do_op($sformatf("rnd%0d", n), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cholesky_array_div.md
CHOLESKY_ARRAY_DIV -- requirements
Module: cholesky_array_div

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low.
REQ-002 The block SHALL be the responder on the shared array-divide channel, serving the dividends/divisor requests issued by the cholesky datapath.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-low reset (0 = reset).
REQ-005 start  in  1  request strobe; sampled only in IDLE or DONE.
REQ-006 dividends  in  [5:0][26:0]  six signed dividends.
REQ-007 divisor  in  [26:0]  one signed divisor shared by all lanes.
REQ-008 quotients  out  [5:0][26:0]  six signed quotients, registered.
REQ-009 busy  out  1  high while iterating.
REQ-010 done  out  1  one-cycle pulse; quotients valid.
REQ-011 dz  out  1  divide-by-zero flag, valid with done.

Function
REQ-012 Number format SHALL be 27-bit two's complement fixed point: 13 integer bits, 13 fractional bits; 1.0 = 8192.
REQ-013 Per lane q = (dividend * 2^13) / divisor, truncated toward zero.
REQ-014 Division SHALL use sign-magnitude: 27-bit operand magnitudes, a 40-bit shifted dividend, and an unsigned restoring divide at one quotient bit per cycle, with all six lanes in parallel.
REQ-015 FSM states SHALL be IDLE, CALC and DONE.
REQ-016 IDLE or DONE, start=1 at edge N: latch dividends and divisor (magnitudes and signs), load the bit counter with 39, enter CALC.
REQ-017 IDLE or DONE, start=0: DONE goes to IDLE; IDLE holds.
REQ-018 CALC: one quotient bit per edge; the counter decrements.
REQ-019 CALC: on the 40th CALC edge (edge N+40), register the final quotients and dz, enter DONE.
REQ-020 done SHALL be 1 exactly during DONE, i.e. the cycle after edge N+40.
REQ-021 busy SHALL be 1 exactly during CALC.
REQ-022 start during CALC SHALL be ignored, and input changes during CALC SHALL have no effect.
REQ-023 A start in DONE SHALL be accepted, giving back-to-back operation with a 41-cycle period.
REQ-024 Saturation: a magnitude result > 2^26-1 SHALL clamp to 2^26-1, then the sign is applied; -2^26 is never produced.
REQ-025 Result sign SHALL be the XOR of the operand signs; a zero result is +0.
REQ-026 divisor == 0: every lane SHALL return +(2^26-1), or -(2^26-1) for a negative dividend (0 dividend -> 0), and dz=1.
REQ-027 Otherwise dz=0.
REQ-028 quotients and dz SHALL hold their value from DONE until the next completion or reset.

Reset
REQ-029 rst=0 at any edge SHALL force IDLE, busy=0, done=0, dz=0, quotients all 0, and counter 0.
REQ-030 Reset mid-CALC SHALL abort the operation with no done pulse.
REQ-031 rst SHALL take priority over start in the same cycle.

Verification
REQ-032 Scenario: lane0 dividend 24576, divisor 16384, start -> done 40 cycles after the start edge; quotients[0]=12288, dz=0; busy high for 40 cycles.
REQ-033 Scenario: signs and truncation, divisor 24576, dividends {8192, -8192, -24576, 0, 24576, -16384} -> {2730, -2730, -8192, 0, 8192, -5461}.
REQ-034 Scenario: divisor 0, dividends {8192, -8192, 0, ...} -> {67108863, 0x4000001, 0, ...}, dz=1.
REQ-035 Scenario: overflow, dividend 0x2000000, divisor 1 -> 67108863; dividend -0x2000000, divisor 1 -> 0x4000001; dz=0.
REQ-036 Scenario: start pulsed again at cycle 10 of CALC with new operands -> ignored; results match the first operands; exactly one done.
REQ-037 Scenario: rst=0 at CALC cycle 20 -> next cycle busy=0, done=0, quotients=0; no done follows; a fresh start afterwards completes normally.
